reg_write_arbiter: RTL and testbench

Shares the register file's single write port between two writeback requesters: A (ALU result) and B (memory load data). Also runs a sequenced clear that zeroes every register, one register per cycle. The block sits between the datapath writeback sources and the register file's WRITEDATA/WRITEREG/WRITEENABLE inputs. It registers every write so the register file always sees stable inputs for a full clock period.

---
 rtl/reg_ctrl_pkg.sv | 17 +
 rtl/rr_arbiter2.sv | 32 +++
 rtl/reg_write_arbiter.sv | 129 ++++++++++++
 tb/tb_reg_write_arbiter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/reg_ctrl_pkg.sv
// Shared types and constants for the register-file write arbiter.
// Holds the FSM state encoding, requester IDs and default geometry.
package reg_ctrl_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam int REQ_A = 0;
    localparam int REQ_B = 1;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 3;
    localparam int DEF_NREGS  = 8;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: combinational one-hot grant, registered priority.
// Priority flips on every advance (accepted grant), contested or not.
module rr_arbiter2
    import reg_ctrl_pkg::*;
(
    input  logic       CLK,
    input  logic       RESET,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    logic r_pri;

    always_comb begin
        gnt = 2'b00;
        if (req[REQ_A] && (!req[REQ_B] || (r_pri == 1'(REQ_A)))) begin
            gnt[REQ_A] = 1'b1;
        end else if (req[REQ_B]) begin
            gnt[REQ_B] = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_pri <= 1'(REQ_A);
        end else if (advance) begin
            r_pri <= ~r_pri;
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Shares the register-file write port between requesters A/B and runs a full-file clear sweep.
// Writes appear one cycle after the handshake; READY is combinational and held low while clearing.
module reg_write_arbiter
    import reg_ctrl_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NREGS  = DEF_NREGS
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              A_VALID,
    input  logic [ADDR_W-1:0] A_ADDR,
    input  logic [DATA_W-1:0] A_DATA,
    output logic              A_READY,
    input  logic              B_VALID,
    input  logic [ADDR_W-1:0] B_ADDR,
    input  logic [DATA_W-1:0] B_DATA,
    output logic              B_READY,
    input  logic              CLEAR_REQ,
    output logic              BUSY,
    output logic [DATA_W-1:0] WRITEDATA,
    output logic [ADDR_W-1:0] WRITEREG,
    output logic              WRITEENABLE
);

    // One extra count bit keeps the terminal compare from wrapping.
    localparam logic [ADDR_W:0] LAST_REG = (ADDR_W+1)'(NREGS - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W:0]   r_count;
    logic [ADDR_W:0]   w_count_nxt;
    logic              r_we;
    logic              w_we_nxt;
    logic [ADDR_W-1:0] r_wreg;
    logic [ADDR_W-1:0] w_wreg_nxt;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] w_wdata_nxt;
    logic              r_busy;
    logic              w_busy_nxt;

    logic              w_arb_open;
    logic [1:0]        w_req;
    logic [1:0]        w_gnt;
    logic              w_advance;

    assign w_arb_open = (r_state == IDLE) && !CLEAR_REQ;
    assign w_req      = {B_VALID & w_arb_open, A_VALID & w_arb_open};
    assign w_advance  = |w_gnt;

    rr_arbiter2 u_arb (
        .CLK     (CLK),
        .RESET   (RESET),
        .req     (w_req),
        .advance (w_advance),
        .gnt     (w_gnt)
    );

    assign A_READY     = w_gnt[REQ_A];
    assign B_READY     = w_gnt[REQ_B];
    assign WRITEENABLE = r_we;
    assign WRITEREG    = r_wreg;
    assign WRITEDATA   = r_wdata;
    assign BUSY        = r_busy;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state <= IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_we_nxt    = 1'b0;
        w_wreg_nxt  = r_wreg;
        w_wdata_nxt = r_wdata;
        w_busy_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (CLEAR_REQ) begin
                    w_state_nxt = CLEAR;
                    w_count_nxt = '0;
                end else if (w_gnt[REQ_A]) begin
                    w_we_nxt    = 1'b1;
                    w_wreg_nxt  = A_ADDR;
                    w_wdata_nxt = A_DATA;
                end else if (w_gnt[REQ_B]) begin
                    w_we_nxt    = 1'b1;
                    w_wreg_nxt  = B_ADDR;
                    w_wdata_nxt = B_DATA;
                end
            end
            CLEAR: begin
                w_we_nxt    = 1'b1;
                w_wreg_nxt  = r_count[ADDR_W-1:0];
                w_wdata_nxt = '0;
                w_busy_nxt  = 1'b1;
                w_count_nxt = r_count + (ADDR_W+1)'(1);
                if (r_count == LAST_REG) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_we    <= 1'b0;
            r_wreg  <= '0;
            r_wdata <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_we    <= w_we_nxt;
            r_wreg  <= w_wreg_nxt;
            r_wdata <= w_wdata_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter: directed scenarios plus random traffic against a queue-based model.
module tb_reg_write_arbiter;

    localparam int DW = 8;
    localparam int AW = 3;
    localparam int NR = 8;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          A_VALID, B_VALID, CLEAR_REQ;
    logic [AW-1:0] A_ADDR, B_ADDR;
    logic [DW-1:0] A_DATA, B_DATA;
    logic          A_READY, B_READY, BUSY, WRITEENABLE;
    logic [DW-1:0] WRITEDATA;
    logic [AW-1:0] WRITEREG;

    always #5 CLK = ~CLK;

    reg_write_arbiter #(.DATA_W(DW), .ADDR_W(AW), .NREGS(NR)) dut (
        .CLK(CLK), .RESET(RESET),
        .A_VALID(A_VALID), .A_ADDR(A_ADDR), .A_DATA(A_DATA), .A_READY(A_READY),
        .B_VALID(B_VALID), .B_ADDR(B_ADDR), .B_DATA(B_DATA), .B_READY(B_READY),
        .CLEAR_REQ(CLEAR_REQ), .BUSY(BUSY),
        .WRITEDATA(WRITEDATA), .WRITEREG(WRITEREG), .WRITEENABLE(WRITEENABLE)
    );

    // Register file fed by the DUT's write port.
    logic [DW-1:0] rf_dut [NR];
    always @(posedge CLK) if (WRITEENABLE) rf_dut[WRITEREG] <= WRITEDATA;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: pending clear writes as a queue of register indices.
    int            clr_q[$];
    bit            m_pri;
    logic          m_we, m_busy;
    logic [AW-1:0] m_wreg;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] rf_exp [NR];

    logic last_ra, last_rb;
    int   busy_seen, gnt_seen;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic void exp_ready(output logic ra, output logic rb);
        logic open_arb;
        open_arb = (clr_q.size() == 0) && !CLEAR_REQ;
        ra = open_arb && A_VALID && (!B_VALID || m_pri == 1'b0);
        rb = open_arb && B_VALID && (!A_VALID || m_pri == 1'b1);
    endfunction

    function automatic void model_reset();
        clr_q.delete();
        m_pri = 1'b0; m_we = 1'b0; m_busy = 1'b0; m_wreg = '0; m_wdata = '0;
    endfunction

    function automatic void model_edge();
        logic ra, rb;
        if (m_we) rf_exp[m_wreg] = m_wdata;
        exp_ready(ra, rb);
        m_we = 1'b0; m_busy = 1'b0;
        if (clr_q.size() > 0) begin
            m_wreg = AW'(clr_q.pop_front());
            m_wdata = '0; m_we = 1'b1; m_busy = 1'b1;
        end else if (CLEAR_REQ) begin
            for (int i = 0; i < NR; i++) clr_q.push_back(i);
        end else if (ra) begin
            m_we = 1'b1; m_wreg = A_ADDR; m_wdata = A_DATA; m_pri = ~m_pri;
        end else if (rb) begin
            m_we = 1'b1; m_wreg = B_ADDR; m_wdata = B_DATA; m_pri = ~m_pri;
        end
    endfunction

    task automatic drive(input logic cr, input logic av, input int aa, input int ad,
                         input logic bv, input int ba, input int bd);
        CLEAR_REQ = cr;
        A_VALID = av; A_ADDR = AW'(aa); A_DATA = DW'(ad);
        B_VALID = bv; B_ADDR = AW'(ba); B_DATA = DW'(bd);
    endtask

    // Entered at posedge+1; returns at the following posedge+1.
    task automatic cycle();
        logic ra, rb;
        #3;
        exp_ready(ra, rb);
        last_ra = A_READY; last_rb = B_READY;
        chk("a_ready", 32'(A_READY), 32'(ra));
        chk("b_ready", 32'(B_READY), 32'(rb));
        if (A_READY || B_READY) gnt_seen++;
        @(posedge CLK);
        model_edge();
        #1;
        if (BUSY) busy_seen++;
        chk("we",    32'(WRITEENABLE), 32'(m_we));
        chk("busy",  32'(BUSY),        32'(m_busy));
        chk("wreg",  32'(WRITEREG),    32'(m_wreg));
        chk("wdata", 32'(WRITEDATA),   32'(m_wdata));
    endtask

    task automatic do_reset();
        RESET = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        @(posedge CLK);
        #1;
        chk("rst_we",    32'(WRITEENABLE), 0);
        chk("rst_busy",  32'(BUSY),        0);
        chk("rst_wreg",  32'(WRITEREG),    0);
        chk("rst_wdata", 32'(WRITEDATA),   0);
        chk("rst_ardy",  32'(A_READY),     0);
        model_reset();
        RESET = 1'b1;
    endtask

    task automatic check_rf(input string tag);
        for (int i = 0; i < NR; i++) chk(tag, 32'(rf_dut[i]), 32'(rf_exp[i]));
    endtask

    initial begin
        RESET = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        do_reset();

        // Single A write.
        drive(0, 1, 2, 95, 0, 0, 0);
        cycle();
        chk("t1_ardy",  32'(last_ra),     1);
        chk("t1_we",    32'(WRITEENABLE), 1);
        chk("t1_wreg",  32'(WRITEREG),    2);
        chk("t1_wdata", 32'(WRITEDATA),   95);
        drive(0, 0, 0, 0, 0, 0, 0);
        cycle();
        chk("t1_we_off", 32'(WRITEENABLE), 0);

        // Both requesters held valid: alternating grants from reset priority.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 1, 28, 1, 4, 6);
            cycle();
            chk("t2_gnt", 32'({last_ra, last_rb}), (i % 2 == 0) ? 32'd2 : 32'd1);
            chk("t2_we", 32'(WRITEENABLE), 1);
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        cycle();

        // Clear wins over a waiting B; B lands right after the sweep.
        busy_seen = 0;
        drive(1, 0, 0, 0, 1, 5, 77);
        cycle();
        chk("t3_brdy_blocked", 32'(last_rb), 0);
        drive(0, 0, 0, 0, 1, 5, 77);
        for (int i = 0; i < NR; i++) begin
            cycle();
            chk("t3_wreg", 32'(WRITEREG), 32'(i));
            chk("t3_wdata", 32'(WRITEDATA), 0);
        end
        cycle();
        chk("t3_busy_cnt", 32'(busy_seen), 8);
        chk("t3_b_after", 32'(WRITEDATA), 77);
        chk("t3_busy_off", 32'(BUSY), 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        cycle();

        // Fill the file with known nonzero values.
        for (int r = 0; r < NR; r++) begin
            drive(0, 1, r, r * 16 + 3, 0, 0, 0);
            cycle();
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        cycle();
        check_rf("fill_rf");

        // Reset mid-sweep while register 3 is being presented.
        drive(1, 0, 0, 0, 0, 0, 0);
        cycle();
        drive(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cycle();
        chk("t4_at3", 32'(WRITEREG), 3);
        #2 RESET = 1'b0;
        #1;
        chk("t4_we_async",   32'(WRITEENABLE), 0);
        chk("t4_busy_async", 32'(BUSY),        0);
        model_reset();
        @(posedge CLK);
        #1 RESET = 1'b1;
        busy_seen = 0;
        for (int i = 0; i < 10; i++) cycle();
        chk("t4_no_resume", 32'(busy_seen), 0);
        check_rf("t4_rf");
        for (int i = 0; i < NR; i++)
            chk("t4_rf_const", 32'(rf_dut[i]), (i < 3) ? 32'd0 : 32'(i * 16 + 3));

        // CLEAR_REQ held high: back-to-back sweeps, no grants.
        busy_seen = 0; gnt_seen = 0;
        drive(1, 1, 1, 11, 1, 2, 22);
        for (int i = 0; i < 20; i++) cycle();
        chk("t5_no_gnt", 32'(gnt_seen), 0);
        chk("t5_busy",   32'(busy_seen), 17);
        drive(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) cycle();

        // Only B valid: three grants, priority toggles each time.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 1, i + 1, (i == 0) ? 15 : (i == 1) ? 50 : 7);
            cycle();
            chk("t6_brdy", 32'(last_rb), 1);
            chk("t6_wdata", 32'(WRITEDATA), (i == 0) ? 32'd15 : (i == 1) ? 32'd50 : 32'd7);
        end
        drive(0, 1, 6, 99, 1, 7, 88);
        cycle();
        chk("t6_pri_b", 32'({last_ra, last_rb}), 1);
        cycle();
        chk("t6_pri_a", 32'({last_ra, last_rb}), 2);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 19) == 0, 1'($urandom), int'($urandom_range(0, NR - 1)),
                  int'($urandom_range(0, 255)), 1'($urandom),
                  int'($urandom_range(0, NR - 1)), int'($urandom_range(0, 255)));
            cycle();
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) cycle();
        check_rf("rand_rf");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
